mouse_pos_tracker: RTL

Parametrised mouse-position-to-LED indicator. It sits between the PS/2 mouse packet unit and the board LED bar.
- Consumes decoded packets: signed deltas, button bits and a one-cycle done tick.
- Keeps an absolute cursor position with saturating or wrapping arithmetic.
- Supports a middle-button freeze mode with a blinking indicator.
- Drives a one-hot LED bar of configurable width.

---
 rtl/mouse_pos_pkg.sv | 26 ++
 rtl/mouse_axis_acc.sv | 56 +++++
 rtl/mouse_pos_tracker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mouse_pos_pkg.sv
// Shared types and helpers for the mouse position tracker.
//   state_t        : tracker FSM states
//   BTN_L/R/M      : bit positions of the buttons in the packet button field
//   clog2()        : ceiling log2, used for LED index and blink counter widths
package mouse_pos_pkg;

   typedef enum logic {
      TRACK  = 1'b0,
      FROZEN = 1'b1
   } state_t;

   localparam int unsigned BTN_L = 0;
   localparam int unsigned BTN_R = 1;
   localparam int unsigned BTN_M = 2;

   // Ceiling log2; clog2(1) = 0
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One-axis absolute position accumulator with saturating or wrapping update.
//   clk, reset : clock, asynchronous active-high reset (pos -> 0)
//   tick       : packet strobe; pos only changes when set
//   hold       : freeze position (ticks ignored)
//   clr / set  : force 0 / force max (clr has priority)
//   delta      : signed two's-complement movement
//   pos        : current position, unsigned
module mouse_axis_acc #(
   parameter int unsigned POS_W    = 10,
   parameter int unsigned DELTA_W  = 9,
   parameter int unsigned SATURATE = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               hold,
   input  logic               clr,
   input  logic               set,
   input  logic [DELTA_W-1:0] delta,
   output logic [POS_W-1:0]   pos
);

   localparam int unsigned SUM_W = POS_W + 2;
   localparam logic signed [SUM_W-1:0] POS_MAX = {2'b00, {POS_W{1'b1}}};

   logic signed [DELTA_W-1:0] delta_s;
   logic signed [SUM_W-1:0]   sum;
   logic [POS_W-1:0]          moved;
   logic [POS_W-1:0]          pos_next;

   // Two guard bits hold both the underflow sign and the overflow carry
   always_comb begin
      delta_s = delta;
      sum     = signed'({2'b00, pos}) + SUM_W'(delta_s);
      moved   = sum[POS_W-1:0];
      if (SATURATE != 0) begin
         if (sum < 0)            moved = '0;
         else if (sum > POS_MAX) moved = '1;
      end
   end

   always_comb begin
      pos_next = pos;
      if (tick && !hold) begin
         if (clr)      pos_next = '0;
         else if (set) pos_next = '1;
         else          pos_next = moved;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pos <= '0;
      else       pos <= pos_next;
   end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Mouse position to one-hot LED bar indicator with middle-button freeze/blink.
// Optional Y axis: define MOUSE_POS_TRACKER_Y_EN to add ym, pos_y, led_y.
//   clk, reset  : clock, asynchronous active-high reset
//   xm          : signed X delta, valid with m_done_tick
//   btnm        : buttons [0] left, [1] right, [2] middle, valid with m_done_tick
//   m_done_tick : one-cycle strobe per decoded packet
//   pos_x       : X position
//   frozen      : high while frozen
//   led         : one-hot position indicator, idx 0 lights the MSB LED
module mouse_pos_tracker
   import mouse_pos_pkg::*;
#(
   parameter int unsigned POS_W     = 10,
   parameter int unsigned DELTA_W   = 9,
   parameter int unsigned NUM_LEDS  = 8,
   parameter int unsigned SATURATE  = 1,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DELTA_W-1:0]  xm,
   input  logic [2:0]          btnm,
   input  logic                m_done_tick,
`ifdef MOUSE_POS_TRACKER_Y_EN
   input  logic [DELTA_W-1:0]  ym,
   output logic [POS_W-1:0]    pos_y,
   output logic [NUM_LEDS-1:0] led_y,
`endif
   output logic [POS_W-1:0]    pos_x,
   output logic                frozen,
   output logic [NUM_LEDS-1:0] led
);

   localparam int unsigned IDX_W = clog2(NUM_LEDS);
   localparam int unsigned CNT_W = (clog2(BLINK_DIV) < 1) ? 1 : clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BLINK_DIV - 1);
   localparam logic [NUM_LEDS-1:0] LED_MSB  = {1'b1, {(NUM_LEDS-1){1'b0}}};

   state_t           state, state_next;
   logic             mid_prev, mid_prev_next;
   logic             mid_rise;
   logic [CNT_W-1:0] blink_cnt, cnt_next;
   logic             phase, phase_next;
   logic             hold;

   assign hold   = (state == FROZEN);
   assign frozen = (state == FROZEN);

   mouse_axis_acc #(.POS_W(POS_W), .DELTA_W(DELTA_W), .SATURATE(SATURATE)) u_acc_x (
      .clk   (clk),
      .reset (reset),
      .tick  (m_done_tick),
      .hold  (hold),
      .clr   (btnm[BTN_L]),
      .set   (btnm[BTN_R]),
      .delta (xm),
      .pos   (pos_x)
   );

`ifdef MOUSE_POS_TRACKER_Y_EN
   mouse_axis_acc #(.POS_W(POS_W), .DELTA_W(DELTA_W), .SATURATE(SATURATE)) u_acc_y (
      .clk   (clk),
      .reset (reset),
      .tick  (m_done_tick),
      .hold  (hold),
      .clr   (btnm[BTN_L]),
      .set   (btnm[BTN_R]),
      .delta (ym),
      .pos   (pos_y)
   );

   assign led_y = (LED_MSB >> pos_y[POS_W-1 -: IDX_W]) & {NUM_LEDS{phase}};
`else
   // X-only build
`endif

   // Position decode, gated by blink phase (phase is 1 outside FROZEN)
   assign led = (LED_MSB >> pos_x[POS_W-1 -: IDX_W]) & {NUM_LEDS{phase}};

   // Next-state: middle-button edge detect, freeze toggle, blink timer
   always_comb begin
      state_next    = state;
      mid_prev_next = mid_prev;
      cnt_next      = blink_cnt;
      phase_next    = phase;
      mid_rise      = 1'b0;

      if (m_done_tick) begin
         mid_prev_next = btnm[BTN_M];
         mid_rise      = btnm[BTN_M] & ~mid_prev;
      end

      case (state)
         TRACK: begin
            cnt_next   = '0;
            phase_next = 1'b1;
            if (mid_rise) state_next = FROZEN;
         end
         FROZEN: begin
            if (mid_rise) begin
               state_next = TRACK;
               cnt_next   = '0;
               phase_next = 1'b1;
            end else if (blink_cnt == CNT_LAST) begin
               cnt_next   = '0;
               phase_next = ~phase;
            end else begin
               cnt_next = blink_cnt + CNT_W'(1);
            end
         end
         default: state_next = TRACK;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= TRACK;
         mid_prev  <= 1'b0;
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else begin
         state     <= state_next;
         mid_prev  <= mid_prev_next;
         blink_cnt <= cnt_next;
         phase     <= phase_next;
      end
   end

endmodule
